// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  typedef logic [1:0] digit_idx_t;

  // Active-low segment patterns, bit0 = a ... bit6 = g, glyphs 0-9 A b C d E F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-synchronous double buffering.
// Optional leading-zero suppression: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int W       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [NUM_DIGITS*W-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  output logic                      load_ack,
  output logic [1:0]                digit_sel,
  output logic                      frame_tick,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0]                cnt;
  logic                         tick;
  logic                         wrap;
  logic                         commit;
  digit_idx_t                   sel_next;

  logic                         pend_valid;
  logic [NUM_DIGITS*W-1:0]      pend_digits, act_digits, nxt_digits;
  logic [NUM_DIGITS-1:0]        pend_dp, act_dp, nxt_dp;
  logic [NUM_DIGITS-1:0]        pend_blank, act_blank, nxt_blank;
  logic [NUM_DIGITS-1:0]        lz;

  logic [W-1:0]                 cur_digit;
  logic [6:0]                   hex_seg;
  logic [6:0]                   seg_next;
  logic                         dp_next;
  logic [NUM_DIGITS-1:0]        an_next;

  assign tick     = (cnt == CW'(CLK_DIV - 1));
  assign wrap     = tick && (digit_sel == 2'd3);
  assign commit   = wrap && pend_valid;
  assign sel_next = digit_sel + 2'd1;

  // Display path looks at the buffer as it will be after this edge, so a
  // committed frame shows starting with its own digit 0.
  assign nxt_digits = commit ? pend_digits : act_digits;
  assign nxt_dp     = commit ? pend_dp     : act_dp;
  assign nxt_blank  = commit ? pend_blank  : act_blank;

  assign cur_digit = nxt_digits[sel_next*W +: W];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    lz    = '0;
    lz[3] = (nxt_digits[4*W-1:3*W] == '0);
    lz[2] = lz[3] && (nxt_digits[3*W-1:2*W] == '0);
    lz[1] = lz[2] && (nxt_digits[2*W-1:W] == '0);
  end
`else
  assign lz = '0;
`endif

  hex_to_seg u_hex_to_seg (
    .nibble (4'(cur_digit)),
    .seg    (hex_seg)
  );

  assign seg_next = (nxt_blank[sel_next] || lz[sel_next]) ? SEG_OFF : hex_seg;
  assign dp_next  = nxt_blank[sel_next] | ~nxt_dp[sel_next];
  assign an_next  = ~(4'b0001 << sel_next);

  // load is a bare one-cycle strobe (always accepted, last write wins);
  // load_ack pulses once, on the wrap edge where the pending buffer goes active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      digit_sel   <= 2'd3;
      pend_valid  <= 1'b0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      load_ack    <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
      cnt        <= tick ? '0 : cnt + 1'b1;

      if (load) begin
        pend_digits <= digits_in;
        pend_dp     <= dp_in;
        pend_blank  <= blank_in;
      end

      if (load)
        pend_valid <= 1'b1;
      else if (commit)
        pend_valid <= 1'b0;

      if (tick) begin
        digit_sel  <= sel_next;
        an         <= an_next;
        seg        <= seg_next;
        dp         <= dp_next;
        frame_tick <= wrap;
        load_ack   <= commit;
        act_digits <= nxt_digits;
        act_dp     <= nxt_dp;
        act_blank  <= nxt_blank;
      end
    end
  end

endmodule
